deserializer_sipo: RTL and testbench

DESERIALIZER_SIPO -- requirements
Module: deserializer_sipo

---
 rtl/deserializer_sipo_if.sv | 22 ++
 rtl/deserializer_sipo.sv | 85 ++++++++
 tb/tb_deserializer_sipo.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/deserializer_sipo_if.sv
// deserializer_sipo_if: serial input, word output handshake and status sideband bundle.
interface deserializer_sipo_if #(
  parameter int DATA_W = 8
);
  logic              bit_en;
  logic              sdi;
  logic              dout_ready;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;
  logic              busy;
  modport master (
    input  bit_en, sdi, dout_ready,
    output dout, dout_valid, parity_err, frame_err, overrun, busy
  );
  modport slave (
    output bit_en, sdi, dout_ready,
    input  dout, dout_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/deserializer_sipo.sv
// deserializer_sipo: start/data/parity/stop frame receiver with a one-word valid/ready output buffer.
module deserializer_sipo #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_EN  = 1,
  parameter bit PARITY_ODD = 0
) (
  input logic                 clk,
  input logic                 rst,
  deserializer_sipo_if.master bus
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d, dout_q, dout_d;
  logic              perr_q, perr_d, dval_q, dval_d, pe_q, pe_d;
  logic              ferr_q, ferr_d, ovr_q, ovr_d;
  logic              done, load;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      perr_q  <= 1'b0;
      dout_q  <= '0;
      dval_q  <= 1'b0;
      pe_q    <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      pe_q    <= pe_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    perr_d  = perr_q;
    ferr_d  = 1'b0;
    done    = 1'b0;
    if (bus.bit_en) begin
      case (state_q)
        IDLE: if (!bus.sdi) begin
          state_d = DATA;
          cnt_d   = '0;
          perr_d  = 1'b0;
        end
        DATA: begin
          sh_d  = {bus.sdi, sh_q[DATA_W-1:1]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) state_d = PARITY_EN ? PARITY : STOP;
        end
        PARITY: begin
          perr_d  = bus.sdi != (^sh_q ^ PARITY_ODD);
          state_d = STOP;
        end
        default: begin
          done    = bus.sdi;
          ferr_d  = !bus.sdi;
          state_d = IDLE;
        end
      endcase
    end
    // a completed word only enters the buffer if it is empty or being drained this edge
    load   = done && (!dval_q || bus.dout_ready);
    dout_d = load ? sh_q : dout_q;
    pe_d   = load ? perr_q : pe_q;
    dval_d = load || (dval_q && !bus.dout_ready);
    ovr_d  = done && !load;
  end
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dval_q;
  assign bus.parity_err = pe_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_deserializer_sipo.sv
// tb_deserializer_sipo: directed frames with a scoreboard queue checked by a separate output monitor.
module tb_deserializer_sipo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  deserializer_sipo_if #(.DATA_W(8)) bus ();
  deserializer_sipo u_dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {logic [7:0] d; logic pe;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, ferr_n = 0, ovr_n = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  // called at a falling edge; returns at a falling edge p cycles later
  task automatic send_bit(input logic b, input int p, input logic eb, input string nm);
    bus.sdi    = b;
    bus.bit_en = 1'b1;
    @(negedge clk);
    bus.bit_en = 1'b0;
    chk(nm, 32'(bus.busy), 32'(eb));
    repeat (p - 1) @(negedge clk);
  endtask
  task automatic send_head(input logic [7:0] d, input logic par, input int p);
    send_bit(1'b0, p, 1'b1, "busy_start");
    for (int i = 0; i < 8; i++) send_bit(d[i], p, 1'b1, "busy_data");
    send_bit(par, p, 1'b1, "busy_parity");
  endtask
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int p);
    send_head(d, par, p);
    send_bit(stop, p, 1'b0, "busy_stop");
    bus.sdi = 1'b1;
  endtask
  task automatic chk_reset_outs();
    chk("rst_dout", 32'(bus.dout), 32'h0);
    chk("rst_dout_valid", 32'(bus.dout_valid), 32'h0);
    chk("rst_parity_err", 32'(bus.parity_err), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
    chk("rst_overrun", 32'(bus.overrun), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        if (bus.frame_err) ferr_n++;
        if (bus.overrun) ovr_n++;
        if (bus.dout_valid && bus.dout_ready) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%0h required=none", bus.dout);
          end else begin
            e = q.pop_front();
            chk("dout", 32'(bus.dout), 32'(e.d));
            chk("parity_err", 32'(bus.parity_err), 32'(e.pe));
          end
        end
      end
    end
  end
  initial begin
    int f0, o0;
    bus.bit_en     = 1'b0;
    bus.sdi        = 1'b1;
    bus.dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outs();
    rst = 1'b1;
    @(negedge clk);
    // 0xA5 held until consumed
    bus.dout_ready = 1'b0;
    q.push_back('{8'hA5, 1'b0});
    send_frame(8'hA5, 1'b0, 1'b1, 1);
    repeat (3) @(negedge clk);
    chk("hold_valid", 32'(bus.dout_valid), 32'h1);
    chk("hold_dout", 32'(bus.dout), 32'hA5);
    bus.dout_ready = 1'b1;
    @(negedge clk);
    chk("valid_clear", 32'(bus.dout_valid), 32'h0);
    // wrong parity bit still delivers the word
    q.push_back('{8'hA5, 1'b1});
    send_frame(8'hA5, 1'b1, 1'b1, 1);
    repeat (2) @(negedge clk);
    // bad stop bit
    f0 = ferr_n;
    send_frame(8'h3C, 1'b0, 1'b0, 1);
    repeat (2) @(negedge clk);
    chk("frame_err_pulses", 32'(ferr_n - f0), 32'h1);
    chk("ferr_no_valid", 32'(bus.dout_valid), 32'h0);
    // back-to-back into a full buffer
    bus.dout_ready = 1'b0;
    o0 = ovr_n;
    q.push_back('{8'h11, 1'b0});
    send_frame(8'h11, 1'b0, 1'b1, 1);
    send_frame(8'h22, 1'b0, 1'b1, 1);
    repeat (2) @(negedge clk);
    chk("overrun_pulses", 32'(ovr_n - o0), 32'h1);
    chk("overrun_keep", 32'(bus.dout), 32'h11);
    bus.dout_ready = 1'b1;
    @(negedge clk);
    chk("overrun_clear", 32'(bus.dout_valid), 32'h0);
    // completion on the same edge the old word is drained
    bus.dout_ready = 1'b0;
    o0 = ovr_n;
    q.push_back('{8'h07, 1'b0});
    q.push_back('{8'hC3, 1'b0});
    send_frame(8'h07, 1'b1, 1'b1, 1);
    send_head(8'hC3, 1'b0, 1);
    bus.dout_ready = 1'b1;
    send_bit(1'b1, 1, 1'b0, "busy_stop");
    bus.sdi = 1'b1;
    chk("swap_valid", 32'(bus.dout_valid), 32'h1);
    repeat (2) @(negedge clk);
    chk("swap_no_overrun", 32'(ovr_n - o0), 32'h0);
    // sparse bit strobe
    q.push_back('{8'h5A, 1'b0});
    send_frame(8'h5A, 1'b0, 1'b1, 4);
    repeat (2) @(negedge clk);
    chk("slow_idle_dout", 32'(bus.dout), 32'h5A);
    // reset mid-frame
    send_bit(1'b0, 1, 1'b1, "busy_start");
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1, 1'b1, "busy_data");
    rst = 1'b0;
    #1;
    chk_reset_outs();
    @(negedge clk);
    rst = 1'b1;
    bus.sdi = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'(bus.busy), 32'h0);
    q.push_back('{8'hFF, 1'b0});
    send_frame(8'hFF, 1'b0, 1'b1, 1);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
